// File: rtl/title_scroller_if.sv
// Signal bundle between the VGA timing/host side, the glyph ROM and title_scroller.
// The master side drives coordinates, buffer writes and ROM data; the slave is the renderer.
interface title_scroller_if #(
    parameter int BUF_DEPTH = 32
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = $clog2(BUF_DEPTH + 1);

    logic [10:0]   x;
    logic [9:0]    y;
    logic          frame_start;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic          len_we;
    logic [LW-1:0] len;
    logic [8:0]    rom_addr;
    logic [7:0]    rom_data;
    logic          blink;
    logic          pixel_on;

    modport master (
        output x, y, frame_start, wr_en, wr_addr, wr_data, len_we, len, rom_data, blink,
        input  rom_addr, pixel_on
    );

    modport slave (
        input  x, y, frame_start, wr_en, wr_addr, wr_data, len_we, len, rom_data, blink,
        output rom_addr, pixel_on
    );
endinterface

// File: rtl/title_scroller.sv
// Marquee title renderer: a row of glyph boxes fed from a writable char buffer and the glyph ROM.
// Defining TITLE_BLINK_EN adds a frame counter that blanks the title every other BLINK_FRAMES frames.
module title_scroller #(
    parameter logic [10:0] X_COORD       = 11'd88,
    parameter logic [9:0]  Y_COORD       = 10'd32,
    parameter int          SCALE_LOG2    = 2,
    parameter int          VISIBLE_CHARS = 12,
    parameter int          BUF_DEPTH     = 32,
    parameter int          GAP           = 2,
    parameter int          SCROLL_DIV    = 4,
    parameter logic [8:0]  BLANK_CODE    = 9'h100,
    parameter int          BLINK_FRAMES  = 32
) (
    input logic             clk,
    input logic             reset,
    title_scroller_if.slave bus
);
    localparam int AW     = $clog2(BUF_DEPTH);
    localparam int LW     = $clog2(BUF_DEPTH + 1);
    localparam int IW     = $clog2(2 * (BUF_DEPTH + GAP) + VISIBLE_CHARS);
    localparam int DW     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BOX_PX = 8 << SCALE_LOG2;

    localparam logic [10:0]   AREA_W   = 11'(VISIBLE_CHARS * BOX_PX);
    localparam logic [9:0]    AREA_H   = 10'(BOX_PX);
    localparam logic [IW-1:0] VIS_I    = IW'(VISIBLE_CHARS);
    localparam logic [IW-1:0] GAP_I    = IW'(GAP);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);

    logic [8:0]    buf_q [BUF_DEPTH];
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] offset_q, offset_d;
    logic [DW-1:0] div_q, div_d;
    logic [8:0]    rom_addr_q, rom_addr_d;
    logic [2:0]    s1_col_q, s1_col_d, s2_col_q, s2_col_d;
    logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic          pixel_on_q, pixel_on_d;
    logic          blink_kill;

    logic [10:0]   rx;
    logic [9:0]    ry;
    logic          in_area;
    logic [IW-1:0] box, len_ext, span, sum, idx;
    logic [2:0]    col, row;
    logic          blank;
    logic [8:0]    code;

    // Geometry and character selection for the pixel currently on x/y.
    always_comb begin
        // NOTE: every variable gets its value on all paths here, so no latch is inferred.
        rx      = bus.x - X_COORD;
        ry      = bus.y - Y_COORD;
        in_area = (bus.x >= X_COORD) && (bus.y >= Y_COORD) && (rx < AREA_W) && (ry < AREA_H);
        box     = IW'(rx >> (3 + SCALE_LOG2));
        col     = rx[SCALE_LOG2 +: 3];
        row     = ry[SCALE_LOG2 +: 3];
        len_ext = IW'(len_q);
        span    = len_ext + GAP_I;
        sum     = offset_q + box;
        if (len_ext <= VIS_I) begin
            idx = box;
        end else begin
            idx = (sum >= span) ? sum - span : sum;
        end
        blank = (idx >= len_ext);
        code  = blank ? BLANK_CODE : buf_q[idx[AW-1:0]];
    end

    // Offset only moves on frame_start; a length load restarts the marquee.
    always_comb begin
        len_d    = len_q;
        offset_d = offset_q;
        div_d    = div_q;
        if (bus.len_we) begin
            len_d    = bus.len;
            offset_d = '0;
            div_d    = '0;
        end else if (bus.frame_start) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (len_ext > VIS_I) begin
                    offset_d = (offset_q == span - IW'(1)) ? '0 : offset_q + IW'(1);
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_comb begin
        rom_addr_d = in_area ? code + {6'd0, row} : BLANK_CODE;
        s1_col_d   = col;
        s1_valid_d = in_area;
        s2_col_d   = s1_col_q;
        s2_valid_d = s1_valid_q;
        pixel_on_d = s2_valid_q & bus.rom_data[3'd7 - s2_col_q] & ~blink_kill;
    end

    // NOTE: the char buffer is deliberately left out of reset; a title survives a reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            buf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            offset_q   <= '0;
            div_q      <= '0;
            rom_addr_q <= '0;
            s1_col_q   <= '0;
            s1_valid_q <= 1'b0;
            s2_col_q   <= '0;
            s2_valid_q <= 1'b0;
            pixel_on_q <= 1'b0;
        end else begin
            len_q      <= len_d;
            offset_q   <= offset_d;
            div_q      <= div_d;
            rom_addr_q <= rom_addr_d;
            s1_col_q   <= s1_col_d;
            s1_valid_q <= s1_valid_d;
            s2_col_q   <= s2_col_d;
            s2_valid_q <= s2_valid_d;
            pixel_on_q <= pixel_on_d;
        end
    end

`ifdef TITLE_BLINK_EN
    localparam int            BW         = $clog2(2 * BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (bus.frame_start) begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
        end
        blink_kill = bus.blink && (blink_cnt_q >= BLINK_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = bus.blink & (BLINK_FRAMES != 0);
    assign blink_kill   = 1'b0;
`endif

    assign bus.rom_addr = rom_addr_q;
    assign bus.pixel_on = pixel_on_q;
endmodule

// File: tb/tb_title_scroller.sv
// Self-checking bench for title_scroller: directed scenarios with literal expectations, then random
// traffic compared every cycle against a frame-count based behavioural model.
module tb_title_scroller;
    localparam int X0    = 88;
    localparam int Y0    = 32;
    localparam int VIS   = 12;
    localparam int GAP   = 2;
    localparam int DIV   = 4;
    localparam int BOXPX = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    title_scroller_if #(.BUF_DEPTH(32)) bus ();

    title_scroller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph ROM: 0x080 row0 = F0, blank glyph all zero, everything else a fixed hash.
    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        logic [7:0] h;
        if (a[8:3] == 6'h20) return 8'h00;
        if (a == 9'h080) return 8'hF0;
        h = a[7:0] * 8'd37 + 8'd11;
        return h ^ {a[8], a[6:0]};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    // Behavioural model: offset derived from pulses counted since the last length load.
    int         m_buf [32];
    int         m_len;
    int         m_pulses;
    int         m_frames;
    logic       e1, e2, e3;
    logic [8:0] e_rom;
    logic       started = 1'b0;
    logic       m_pix;
    logic [8:0] m_ra;
    logic       m_kill;

    task automatic model_lookup(input int xx, input int yy, output logic pix, output logic [8:0] ra);
        int rx, ry, box, col, row, idx, code, off;
        logic [7:0] glyph_row;
        pix = 1'b0;
        ra  = 9'h100;
        if (xx >= X0 && yy >= Y0 && xx - X0 < VIS * BOXPX && yy - Y0 < BOXPX) begin
            rx  = xx - X0;
            ry  = yy - Y0;
            box = rx / BOXPX;
            col = (rx / 4) % 8;
            row = (ry / 4) % 8;
            off = (m_len > VIS) ? (m_pulses / DIV) % (m_len + GAP) : 0;
            idx = (m_len > VIS) ? (off + box) % (m_len + GAP) : box;
            code = (idx >= m_len) ? 'h100 : m_buf[idx];
            ra   = 9'(code + row);
            glyph_row = rom_fn(ra);
            pix  = glyph_row[7 - col];
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            started  = 1'b1;
            e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
            e_rom    = 9'h000;
            m_len    = 0;
            m_pulses = 0;
            m_frames = 0;
        end else begin
            model_lookup(int'(bus.x), int'(bus.y), m_pix, m_ra);
`ifdef TITLE_BLINK_EN
            m_kill = bus.blink && ((m_frames % 64) >= 32);
`else
            m_kill = 1'b0;
`endif
            e3    = e2 & ~m_kill;
            e2    = e1;
            e1    = m_pix;
            e_rom = m_ra;
            if (bus.wr_en) m_buf[bus.wr_addr] = int'(bus.wr_data);
            if (bus.len_we) begin
                m_len    = int'(bus.len);
                m_pulses = 0;
            end else if (bus.frame_start) begin
                m_pulses++;
            end
            if (bus.frame_start) m_frames++;
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("cyc_pixel_on", 32'(bus.pixel_on), 32'(e3));
            check("cyc_rom_addr", 32'(bus.rom_addr), 32'(e_rom));
        end
    end

    task automatic write_buf(input int a, input logic [8:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic set_len(input int l);
        @(negedge clk);
        bus.len_we = 1'b1; bus.len = 6'(l);
        @(negedge clk);
        bus.len_we = 1'b0;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.frame_start = 1'b1;
            @(negedge clk);
            bus.frame_start = 1'b0;
        end
    endtask

    logic exp_blink_pix;

    initial begin
        reset = 1'b1;
        bus.x = '0; bus.y = '0; bus.frame_start = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.len_we = 1'b0; bus.len = '0; bus.blink = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("t1_reset_pixel", 32'(bus.pixel_on), 32'd0);
        check("t1_reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) write_buf(i, 9'($urandom_range(0, 31) * 8));

        // Box 0 glyph top-left, then column 4 of the same row.
        write_buf(0, 9'h080);
        set_len(12);
        bus.x = 11'd88; bus.y = 10'd32;
        @(negedge clk);
        check("t2_rom_addr", 32'(bus.rom_addr), 32'h080);
        repeat (2) @(negedge clk);
        check("t2_pixel", 32'(bus.pixel_on), 32'd1);
        check("t2_model_pixel", 32'(e3), 32'd1);
        bus.x = 11'd104;
        repeat (3) @(negedge clk);
        check("t2_col4_pixel", 32'(bus.pixel_on), 32'd0);

        // Just outside the area on both axes.
        bus.x = 11'd87; bus.y = 10'd32;
        @(negedge clk);
        check("t3_left_rom_addr", 32'(bus.rom_addr), 32'h100);
        repeat (2) @(negedge clk);
        check("t3_left_pixel", 32'(bus.pixel_on), 32'd0);
        bus.x = 11'd100; bus.y = 10'd64;
        @(negedge clk);
        check("t3_below_rom_addr", 32'(bus.rom_addr), 32'h100);
        repeat (2) @(negedge clk);
        check("t3_below_pixel", 32'(bus.pixel_on), 32'd0);

        // Marquee with len=16: offsets cycle through 0..17.
        bus.x = 11'd88; bus.y = 10'd32;
        write_buf(0, 9'h010);
        write_buf(1, 9'h080);
        write_buf(5, 9'h0A8);
        set_len(16);
        pulse(3);
        @(negedge clk);
        check("t4_three_pulses", 32'(bus.rom_addr), 32'h010);
        pulse(1);
        @(negedge clk);
        check("t4_four_pulses", 32'(bus.rom_addr), 32'h080);
        repeat (2) @(negedge clk);
        check("t4_four_pulses_pixel", 32'(bus.pixel_on), 32'd1);
        pulse(60);
        @(negedge clk);
        check("t4_gap_rom_addr", 32'(bus.rom_addr), 32'h100);
        check("t4_model_gap", 32'(e_rom), 32'h100);
        repeat (2) @(negedge clk);
        check("t4_gap_pixel", 32'(bus.pixel_on), 32'd0);
        pulse(8);
        @(negedge clk);
        check("t4_wrap_rom_addr", 32'(bus.rom_addr), 32'h010);

        // Length load beats a coincident frame_start and clears the divider.
        pulse(22);
        @(negedge clk);
        check("t5_offset5", 32'(bus.rom_addr), 32'h0A8);
        @(negedge clk);
        bus.len_we = 1'b1; bus.len = 6'd16; bus.frame_start = 1'b1;
        @(negedge clk);
        bus.len_we = 1'b0; bus.frame_start = 1'b0;
        @(negedge clk);
        check("t5_offset_cleared", 32'(bus.rom_addr), 32'h010);
        pulse(3);
        @(negedge clk);
        check("t5_divider_cleared", 32'(bus.rom_addr), 32'h010);
        pulse(1);
        @(negedge clk);
        check("t5_first_step", 32'(bus.rom_addr), 32'h080);

        // Reset while drawing: pipeline flushed, pixels return only through the full latency.
        write_buf(0, 9'h080);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.len_we = 1'b1; bus.len = 6'd12;
        check("t6_reset_pixel", 32'(bus.pixel_on), 32'd0);
        check("t6_reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        bus.len_we = 1'b0;
        check("t6_release1", 32'(bus.pixel_on), 32'd0);
        repeat (2) @(negedge clk);
        check("t6_release3", 32'(bus.pixel_on), 32'd0);
        @(negedge clk);
        check("t6_release4", 32'(bus.pixel_on), 32'd1);

        // Blink: frames 0-31 drawn, 32-63 blanked only when the feature is built in.
        bus.blink = 1'b1;
        pulse(31);
        repeat (3) @(negedge clk);
        check("t7_frame31_pixel", 32'(bus.pixel_on), 32'd1);
        pulse(1);
        @(negedge clk);
`ifdef TITLE_BLINK_EN
        exp_blink_pix = 1'b0;
`else
        exp_blink_pix = 1'b1;
`endif
        check("t7_frame32_pixel", 32'(bus.pixel_on), 32'(exp_blink_pix));
        pulse(32);
        @(negedge clk);
        check("t7_frame64_pixel", 32'(bus.pixel_on), 32'd1);

        // Random traffic against the model.
        set_len(20);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            bus.x = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047))
                                                 : 11'($urandom_range(80, 480));
            bus.y = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                 : 10'($urandom_range(28, 68));
            bus.frame_start = ($urandom_range(0, 3) == 0);
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_addr = 5'($urandom_range(0, 31));
            bus.wr_data = 9'($urandom_range(0, 31) * 8);
            bus.len_we  = ($urandom_range(0, 199) == 0);
            bus.len     = 6'($urandom_range(0, 32));
            bus.blink   = 1'($urandom_range(0, 1));
        end
        reset = 1'b0;
        bus.frame_start = 1'b0; bus.wr_en = 1'b0; bus.len_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
